// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared widths, FSM encoding and ALU op codes for the ALU arbiter
package alu_arb_pkg;

   localparam int DATA_W        = 32;
   localparam int OP_W          = 4;
   localparam int SH_W          = 5;
   localparam int ALU_SHAMT_SEL = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_NEG  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_SLL  = 3'b100;
   localparam logic [2:0] ALU_SRL  = 3'b101;
   localparam logic [2:0] ALU_SRA  = 3'b110;
   localparam logic [2:0] ALU_DIFF = 3'b111;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// rtl/alu_rr_arbiter_if.sv - requester, ALU and response signals of the ALU arbiter
interface alu_rr_arbiter_if;
   import alu_arb_pkg::*;

   logic              r0_valid;
   logic              r0_ready;
   logic [OP_W-1:0]   r0_op;
   logic [DATA_W-1:0] r0_a;
   logic [DATA_W-1:0] r0_b;
   logic [SH_W-1:0]   r0_shamt;

   logic              r1_valid;
   logic              r1_ready;
   logic [OP_W-1:0]   r1_op;
   logic [DATA_W-1:0] r1_a;
   logic [DATA_W-1:0] r1_b;
   logic [SH_W-1:0]   r1_shamt;

   logic [DATA_W-1:0] alu_inp1;
   logic [DATA_W-1:0] alu_inp2;
   logic [SH_W-1:0]   alu_shamt;
   logic [OP_W-1:0]   alu_ctrl;
   logic [DATA_W-1:0] alu_out;
   logic              alu_carry;
   logic              alu_neg;
   logic              alu_zero;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_carry;
   logic              rsp_neg;
   logic              rsp_zero;

   modport master (
      output r0_valid, r0_op, r0_a, r0_b, r0_shamt,
      output r1_valid, r1_op, r1_a, r1_b, r1_shamt,
      output alu_out, alu_carry, alu_neg, alu_zero, rsp_ready,
      input  r0_ready, r1_ready,
      input  alu_inp1, alu_inp2, alu_shamt, alu_ctrl,
      input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_neg, rsp_zero
   );

   modport slave (
      input  r0_valid, r0_op, r0_a, r0_b, r0_shamt,
      input  r1_valid, r1_op, r1_a, r1_b, r1_shamt,
      input  alu_out, alu_carry, alu_neg, alu_zero, rsp_ready,
      output r0_ready, r1_ready,
      output alu_inp1, alu_inp2, alu_shamt, alu_ctrl,
      output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_neg, rsp_zero
   );

endinterface

// File: rtl/alu_rr_arbiter_rr_arb2.sv
// rtl/alu_rr_arbiter_rr_arb2.sv - two-way priority grant, one-hot or zero
module rr_arb2 (
   input  logic [1:0] i_v,
   input  logic       i_prio,
   output logic [1:0] o_gnt
);

   // On contention the requester whose index equals i_prio wins.
   assign o_gnt[0] = i_v[0] & (~i_v[1] | ~i_prio);
   assign o_gnt[1] = i_v[1] & (~i_v[0] |  i_prio);

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_rr_arbiter
   import alu_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   alu_rr_arbiter_if.slave   bus
);

   state_t            r_state;
   state_t            w_next_state;
   logic              r_prio;
   logic [1:0]        w_gnt;
   logic [1:0]        w_ready;

   logic [OP_W-1:0]   r_op;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [SH_W-1:0]   r_shamt;
   logic              r_id;

   logic              r_rsp_valid;
   logic              r_rsp_id;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_carry;
   logic              r_rsp_neg;
   logic              r_rsp_zero;

   rr_arb2 u_arb (
      .i_v    ({bus.r1_valid, bus.r0_valid}),
      .i_prio (r_prio),
      .o_gnt  (w_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_ready      = 2'b00;
      case (r_state)
         ST_IDLE: begin
            w_ready = w_gnt;
            if (|w_gnt) w_next_state = ST_EXEC;
         end
         ST_EXEC: w_next_state = ST_RESP;
         ST_RESP: if (bus.rsp_ready) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Issue registers alone feed the ALU, so requester ports may change freely after grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_shamt     <= '0;
         r_id        <= 1'b0;
         r_prio      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_neg   <= 1'b0;
         r_rsp_zero  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_ready[1]) begin
                  r_op    <= bus.r1_op;
                  r_a     <= bus.r1_a;
                  r_b     <= bus.r1_b;
                  r_shamt <= bus.r1_shamt;
                  r_id    <= 1'b1;
               end else if (w_ready[0]) begin
                  r_op    <= bus.r0_op;
                  r_a     <= bus.r0_a;
                  r_b     <= bus.r0_b;
                  r_shamt <= bus.r0_shamt;
                  r_id    <= 1'b0;
               end
            end
            ST_EXEC: begin
               r_rsp_valid <= 1'b1;
               r_rsp_id    <= r_id;
               r_rsp_data  <= bus.alu_out;
               r_rsp_carry <= bus.alu_carry;
               r_rsp_neg   <= bus.alu_neg;
               r_rsp_zero  <= bus.alu_zero;
            end
            ST_RESP: begin
               // Priority moves only at handoff, so a lone requester can win back-to-back.
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_prio      <= ~r_rsp_id;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.r0_ready  = w_ready[0];
   assign bus.r1_ready  = w_ready[1];
   assign bus.alu_inp1  = r_a;
   assign bus.alu_inp2  = r_b;
   assign bus.alu_shamt = r_shamt;
   assign bus.alu_ctrl  = r_op;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_carry = r_rsp_carry;
   assign bus.rsp_neg   = r_rsp_neg;
   assign bus.rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - directed self-checking bench for alu_rr_arbiter
module tb_alu_rr_arbiter;
   import alu_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_rr_arbiter_if bus ();

   alu_rr_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU standing in for the real instance
   logic [4:0]  alu_sh;
   logic [32:0] alu_sum;
   logic [31:0] alu_res;
   always_comb begin
      alu_sh  = bus.alu_ctrl[ALU_SHAMT_SEL] ? bus.alu_shamt : bus.alu_inp2[4:0];
      alu_sum = '0;
      alu_res = '0;
      case (bus.alu_ctrl[2:0])
         ALU_ADD:  begin alu_sum = {1'b0, bus.alu_inp1} + {1'b0, bus.alu_inp2}; alu_res = alu_sum[31:0]; end
         ALU_NEG:  begin alu_sum = {1'b0, ~bus.alu_inp1} + 33'd1; alu_res = alu_sum[31:0]; end
         ALU_AND:  alu_res = bus.alu_inp1 & bus.alu_inp2;
         ALU_XOR:  alu_res = bus.alu_inp1 ^ bus.alu_inp2;
         ALU_SLL:  alu_res = bus.alu_inp1 << alu_sh;
         ALU_SRL:  alu_res = bus.alu_inp1 >> alu_sh;
         ALU_SRA:  alu_res = $unsigned($signed(bus.alu_inp1) >>> alu_sh);
         default:  begin alu_sum = {1'b0, bus.alu_inp1} + {1'b0, ~bus.alu_inp2} + 33'd1; alu_res = alu_sum[31:0]; end
      endcase
      bus.alu_out   = alu_res;
      bus.alu_carry = alu_sum[32];
      bus.alu_neg   = alu_res[31];
      bus.alu_zero  = (alu_res == 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.r0_valid = 0; bus.r0_op = '0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_shamt = '0;
      bus.r1_valid = 0; bus.r1_op = '0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_shamt = '0;
      bus.rsp_ready = 0;
      rst = 1;
      repeat (2) tick();
      n_cmp++; if (bus.r0_ready !== 1'b0) begin n_err++; $display("FAIL reset_r0_ready got=%b exp=0", bus.r0_ready); end
      n_cmp++; if (bus.r1_ready !== 1'b0) begin n_err++; $display("FAIL reset_r1_ready got=%b exp=0", bus.r1_ready); end
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id got=%b exp=0", bus.rsp_id); end
      n_cmp++; if (bus.rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
      n_cmp++; if ({bus.alu_inp1, bus.alu_inp2, bus.alu_shamt, bus.alu_ctrl} !== 73'd0) begin n_err++; $display("FAIL reset_alu_outputs got=%h exp=0", {bus.alu_inp1, bus.alu_inp2, bus.alu_shamt, bus.alu_ctrl}); end
      rst = 0;
   endtask

   task automatic test_single();
      bus.r0_valid = 1; bus.r0_op = 4'b0000; bus.r0_a = 32'd5; bus.r0_b = 32'd7; bus.r0_shamt = '0;
      #1;
      n_cmp++; if (bus.r0_ready !== 1'b1) begin n_err++; $display("FAIL single_grant_r0 got=%b exp=1", bus.r0_ready); end
      n_cmp++; if (bus.r1_ready !== 1'b0) begin n_err++; $display("FAIL single_no_r1 got=%b exp=0", bus.r1_ready); end
      tick();
      bus.r0_valid = 0;
      n_cmp++; if (bus.r0_ready !== 1'b0) begin n_err++; $display("FAIL single_exec_ready got=%b exp=0", bus.r0_ready); end
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_exec_rsp_valid got=%b exp=0", bus.rsp_valid); end
      n_cmp++; if (bus.alu_inp1 !== 32'd5 || bus.alu_inp2 !== 32'd7) begin n_err++; $display("FAIL single_issue_ops got=%h/%h exp=5/7", bus.alu_inp1, bus.alu_inp2); end
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got=%b exp=1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL single_rsp_id got=%b exp=0", bus.rsp_id); end
      n_cmp++; if (bus.rsp_data !== 32'd12) begin n_err++; $display("FAIL single_rsp_data got=%h exp=c", bus.rsp_data); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_handoff got=%b exp=0", bus.rsp_valid); end
   endtask

   task automatic test_contend();
      rst = 1; #2; rst = 0;
      tick();
      bus.r0_valid = 1; bus.r0_op = 4'b0010; bus.r0_a = 32'hF0F0F0F0; bus.r0_b = 32'hFF00FF00;
      bus.r1_valid = 1; bus.r1_op = 4'b0100; bus.r1_a = 32'h1; bus.r1_b = 32'h4; bus.r1_shamt = '0;
      #1;
      n_cmp++; if ({bus.r1_ready, bus.r0_ready} !== 2'b01) begin n_err++; $display("FAIL contend_first_grant got=%b exp=01", {bus.r1_ready, bus.r0_ready}); end
      tick();
      bus.r0_valid = 0;
      n_cmp++; if (bus.r1_ready !== 1'b0) begin n_err++; $display("FAIL contend_exec_r1_ready got=%b exp=0", bus.r1_ready); end
      tick();
      n_cmp++; if (bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'hF000F000) begin n_err++; $display("FAIL contend_rsp0 got=%b/%h exp=0/f000f000", bus.rsp_id, bus.rsp_data); end
      n_cmp++; if (bus.rsp_neg !== 1'b1) begin n_err++; $display("FAIL contend_rsp0_neg got=%b exp=1", bus.rsp_neg); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
      n_cmp++; if (bus.r1_ready !== 1'b1) begin n_err++; $display("FAIL contend_second_grant got=%b exp=1", bus.r1_ready); end
      tick();
      bus.r1_valid = 0;
      n_cmp++; if (bus.alu_inp2 !== 32'h4 || bus.alu_ctrl !== 4'b0100) begin n_err++; $display("FAIL contend_issue_r1 got=%h/%b exp=4/0100", bus.alu_inp2, bus.alu_ctrl); end
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'h10) begin n_err++; $display("FAIL contend_rsp1 got=%b/%b/%h exp=1/1/10", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
   endtask

   task automatic test_fairness();
      logic [5:0] ids;
      int         n;
      int         cyc;
      logic [31:0] exp_data;
      ids = '0; n = 0; cyc = 0;
      bus.r0_valid = 1; bus.r0_op = 4'b0000; bus.r0_a = 32'd100; bus.r0_b = 32'd1;
      bus.r1_valid = 1; bus.r1_op = 4'b0111; bus.r1_a = 32'd100; bus.r1_b = 32'd1;
      bus.rsp_ready = 1;
      while (n < 6 && cyc < 60) begin
         tick();
         cyc++;
         if (bus.rsp_valid) begin
            ids[n] = bus.rsp_id;
            exp_data = bus.rsp_id ? 32'd99 : 32'd101;
            n_cmp++; if (bus.rsp_data !== exp_data) begin n_err++; $display("FAIL fair_data_%0d got=%h exp=%h", n, bus.rsp_data, exp_data); end
            n++;
         end
      end
      bus.r0_valid = 0; bus.r1_valid = 0;
      tick();
      bus.rsp_ready = 0;
      n_cmp++; if (n != 6) begin n_err++; $display("FAIL fair_count got=%0d exp=6", n); end
      n_cmp++; if (ids !== 6'b101010) begin n_err++; $display("FAIL fair_id_seq got=%b exp=101010 (bit0 first)", ids); end
   endtask

   task automatic test_backpressure_shift();
      bus.r0_valid = 1; bus.r0_op = 4'b0011; bus.r0_a = 32'h0000FFFF; bus.r0_b = 32'h00FF00FF;
      bus.r1_valid = 1; bus.r1_op = 4'b1100; bus.r1_a = 32'h80000000; bus.r1_b = 32'h0; bus.r1_shamt = 5'd4;
      bus.rsp_ready = 0;
      #1;
      n_cmp++; if ({bus.r1_ready, bus.r0_ready} !== 2'b01) begin n_err++; $display("FAIL bp_grant got=%b exp=01", {bus.r1_ready, bus.r0_ready}); end
      tick();
      bus.r0_valid = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h00FFFF00) begin n_err++; $display("FAIL bp_hold_%0d got=%b/%b/%h exp=1/0/00ffff00", i, bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
         n_cmp++; if ({bus.r1_ready, bus.r0_ready} !== 2'b00) begin n_err++; $display("FAIL bp_no_grant_%0d got=%b exp=00", i, {bus.r1_ready, bus.r0_ready}); end
         tick();
      end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
      n_cmp++; if (bus.r1_ready !== 1'b1) begin n_err++; $display("FAIL bp_then_r1 got=%b exp=1", bus.r1_ready); end
      tick();
      bus.r1_valid = 0;
      n_cmp++; if (bus.alu_ctrl !== 4'b1100 || bus.alu_shamt !== 5'd4 || bus.alu_inp1 !== 32'h80000000) begin n_err++; $display("FAIL shift_issue got=%b/%0d/%h exp=1100/4/80000000", bus.alu_ctrl, bus.alu_shamt, bus.alu_inp1); end
      bus.rsp_ready = 1;
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_zero !== 1'b1) begin n_err++; $display("FAIL shift_rsp got=%b/%b/%h/z%b exp=1/1/0/z1", bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_zero); end
      tick();
      bus.rsp_ready = 0;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL shift_handoff got=%b exp=0", bus.rsp_valid); end
   endtask

   task automatic test_reset_mid();
      bus.r0_valid = 1; bus.r0_op = 4'b0000; bus.r0_a = 32'd1; bus.r0_b = 32'd2;
      tick();
      bus.r0_valid = 0;
      tick();
      n_cmp++; if (bus.rsp_data !== 32'd3 || bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL rmid_pre_rsp got=%h/%b exp=3/0", bus.rsp_data, bus.rsp_id); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
      bus.r0_valid = 1; bus.r0_op = 4'b0000; bus.r0_a = 32'h55; bus.r0_b = 32'd1;
      tick();
      bus.r0_valid = 0;
      #2;
      rst = 1;
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.alu_inp1 !== 32'd0) begin n_err++; $display("FAIL rmid_async_clear got=%b/%h exp=0/0", bus.rsp_valid, bus.alu_inp1); end
      #1;
      rst = 0;
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_rsp got=%b exp=0", bus.rsp_valid); end
      bus.r0_valid = 1; bus.r0_op = 4'b0010; bus.r0_a = 32'hFFFF0000; bus.r0_b = 32'h0F0F0F0F;
      bus.r1_valid = 1; bus.r1_op = 4'b0000; bus.r1_a = 32'd1; bus.r1_b = 32'd1;
      #1;
      n_cmp++; if ({bus.r1_ready, bus.r0_ready} !== 2'b01) begin n_err++; $display("FAIL rmid_prio_reset got=%b exp=01", {bus.r1_ready, bus.r0_ready}); end
      tick();
      bus.r0_valid = 0; bus.r1_valid = 0;
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h0F0F0000) begin n_err++; $display("FAIL rmid_post_rsp got=%b/%b/%h exp=1/0/0f0f0000", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_handoff got=%b exp=0", bus.rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contend();
      test_fairness();
      test_backpressure_shift();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
